cache_nway_wt: RTL and testbench

//  Parametrised N-way set-associative, write-through, no-write-allocate cache between a CPU port and a backing RAM port.
//  One word per line; per-set round-robin replacement that fills invalid ways first.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_victim_sel.sv | 28 ++
 rtl/cache_nway_wt.sv | 233 +++++++++++++++++++++++
 tb/tb_cache_nway_wt.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the N-way write-through cache: controller FSM
// encoding and an elaboration-time ceil(log2) helper.
package cache_pkg;

  // Controller states, in the order a request normally walks through them.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_RD   = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    MEM_WR   = 3'd5,
    RESP     = 3'd6
  } state_t;

  // Ceiling log2 for sizing index/way fields from power-of-two parameters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection for a line fill: the lowest-index invalid way wins;
// when every way is valid the set's round-robin pointer decides, and use_rr
// tells the caller to advance that pointer.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim,
  output logic             use_rr
);

  // Scan from the top down so the lowest invalid way is the last to overwrite.
  always_comb begin
    victim = rr_ptr;
    use_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim = WAY_W'(w);
        use_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_nway_wt.sv
// N-way set-associative, write-through, no-write-allocate cache with one
// word per line, round-robin replacement and valid/ready handshakes on both
// the CPU and RAM sides.
// Optional feature: define CACHE_STATS_EN to add saturating 32-bit hit_cnt
// and miss_cnt outputs (counted once per request in LOOKUP).
module cache_nway_wt
  import cache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = clog2(WAYS);

  // Controller and request latch
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_hit_q, rsp_hit_d;

  // Line storage, indexed [set][way]
  logic [DATA_W-1:0]   data_q  [SETS][WAYS];
  logic [DATA_W-1:0]   data_d  [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]    tag_d   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [WAY_W-1:0]    rr_q    [SETS];
  logic [WAY_W-1:0]    rr_d    [SETS];

  // Decoded view of the latched request
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                lk_hit;
  logic [WAY_W-1:0]    lk_way;
  logic [WAY_W-1:0]    vic_way;
  logic                vic_use_rr;

`ifdef CACHE_STATS_EN
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  // Counters stick at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  // Parallel tag compare across the selected set; at most one way can match
  // because a fill only happens after a miss on that same tag.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  cache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid  (valid_q[idx]),
    .rr_ptr (rr_q[idx]),
    .victim (vic_way),
    .use_rr (vic_use_rr)
  );

  // Next-state, request latch, array update and response register logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    fill_d      = fill_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_hit_d   = rsp_hit_q;
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
`ifdef CACHE_STATS_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wr_d    = req_wr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
`ifdef CACHE_STATS_EN
        if (lk_hit) hit_cnt_d = sat_inc(hit_cnt_q);
        else        miss_cnt_d = sat_inc(miss_cnt_q);
`endif
        if (wr_q) begin
          // Write-through: refresh a resident copy, never allocate on a miss.
          if (lk_hit) data_d[idx][lk_way] = wdata_q;
          rsp_hit_d = lk_hit;
          state_d   = MEM_WR;
        end else if (lk_hit) begin
          rsp_rdata_d = data_q[idx][lk_way];
          rsp_hit_d   = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          fill_d  = mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        data_d[idx][vic_way]  = fill_q;
        tag_d[idx][vic_way]   = tag;
        valid_d[idx][vic_way] = 1'b1;
        // Only a replacement of a live line consumes the round-robin slot.
        if (vic_use_rr) rr_d[idx] = rr_q[idx] + WAY_W'(1);
        rsp_rdata_d = fill_q;
        rsp_hit_d   = 1'b0;
        state_d     = RESP;
      end
      MEM_WR: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control, tag-valid bookkeeping and visible outputs; reset invalidates
  // every line and abandons any in-flight RAM request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_hit_q   <= 1'b0;
      valid_q     <= '{default: '0};
      rr_q        <= '{default: '0};
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_hit_q   <= rsp_hit_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  // Line payload and fill buffer; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
    fill_q <= fill_d;
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_hit       = rsp_hit_q;
  assign mem_req_valid = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_wr        = (state_q == MEM_WR);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

`ifdef CACHE_STATS_EN
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway_wt.sv
// Scoreboard bench for cache_nway_wt with a handshaking RAM model.
module tb_cache_nway_wt;

  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_nway_wt #(
    .WAYS   (WAYS),
    .SETS   (SETS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_hit       (rsp_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  typedef struct packed {
    logic        hit;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        chk_lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mem_acc = 0;
  int   ready_delay = 0;
  int   rsp_delay = 0;
  bit   mem_hold = 1'b0;
  logic [31:0] bmem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // RAM model: ready after ready_delay cycles, read data rsp_delay cycles after accept.
  initial begin : ram_model
    int rdy_cnt;
    int rsp_cnt;
    bit pending;
    logic [31:0] rd_word;
    rdy_cnt = 0; rsp_cnt = 0; pending = 1'b0; rd_word = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (rst) begin
        rdy_cnt = 0;
        pending = 1'b0;
      end else if (pending) begin
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = rd_word;
          pending       = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end else if (mem_req_valid && !mem_hold) begin
        if (rdy_cnt < ready_delay) begin
          rdy_cnt++;
        end else begin
          rdy_cnt = 0;
          mem_req_ready = 1'b1;
          mem_acc++;
          if (mem_wr) begin
            bmem[mem_addr] = mem_wdata;
          end else begin
            rd_word = ram_read(mem_addr);
            pending = 1'b1;
            rsp_cnt = rsp_delay;
          end
        end
      end
    end
  end

  // Monitor: every response is popped against the oldest expectation.
  initial begin : monitor
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (prev) begin
          total++; bad++;
          $display("FAIL rsp_pulse_width: rsp_valid high on consecutive cycles at %0d", cyc);
        end
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard at %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_hit", {31'b0, rsp_hit}, {31'b0, e.hit});
          if (e.chk_rd) check("rsp_rdata", rsp_rdata, e.rdata);
          if (e.chk_lat) check("hit_latency", cyc - e.acc, 32'd2);
        end
      end
      prev = (rsp_valid === 1'b1);
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic push, input logic eh, input logic [31:0] erd,
                       input logic crd, input logic clat);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: addr %h", a);
    end
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    e.acc     = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    if (push) begin
      e.hit     = eh;
      e.rdata   = erd;
      e.chk_rd  = crd;
      e.chk_lat = clat;
      sb.push_back(e);
    end
  endtask

  // One complete request: issue, wait for its response, check RAM traffic.
  task automatic op(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                    input logic eh, input logic [31:0] erd, input logic crd,
                    input logic clat, input int emem);
    int m0;
    int n;
    m0 = mem_acc;
    issue(wr, a, wd, 1'b1, eh, erd, crd, clat);
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL rsp_timeout: addr %h", a);
      sb.delete();
    end
    @(negedge clk);
    check("mem_req_count", mem_acc - m0, emem);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bmem[32'h10] = 32'hA5A5_0001;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_hit", {31'b0, rsp_hit}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Test 1: cold miss then hit
    ready_delay = 3; rsp_delay = 3;
    op(1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1);
    op(1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 0);

    // Test 2: five tags into set 0, round-robin eviction
    pulse_reset();
    ready_delay = 0; rsp_delay = 0;
    op(1'b0, 32'h00, 32'h0, 1'b0, 32'hC0DE_0000, 1'b1, 1'b0, 1);
    op(1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1);
    op(1'b0, 32'h20, 32'h0, 1'b0, 32'hC0DE_0020, 1'b1, 1'b0, 1);
    op(1'b0, 32'h30, 32'h0, 1'b0, 32'hC0DE_0030, 1'b1, 1'b0, 1);
    op(1'b0, 32'h40, 32'h0, 1'b0, 32'hC0DE_0040, 1'b1, 1'b0, 1);
    op(1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 0);
    op(1'b0, 32'h20, 32'h0, 1'b1, 32'hC0DE_0020, 1'b1, 1'b1, 0);
    op(1'b0, 32'h30, 32'h0, 1'b1, 32'hC0DE_0030, 1'b1, 1'b1, 0);
    op(1'b0, 32'h40, 32'h0, 1'b1, 32'hC0DE_0040, 1'b1, 1'b1, 0);
    op(1'b0, 32'h00, 32'h0, 1'b0, 32'hC0DE_0000, 1'b1, 1'b0, 1);

    // Test 3: write hit goes through to RAM and updates the line
    ready_delay = 1; rsp_delay = 2;
    op(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0, 1);
    op(1'b0, 32'h20, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 0);
    op(1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1);
    op(1'b0, 32'h20, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1);
    op(1'b0, 32'h40, 32'h0, 1'b1, 32'hC0DE_0040, 1'b1, 1'b1, 0);

    // Test 4: write miss does not allocate
    op(1'b1, 32'h55, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    op(1'b0, 32'h55, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1);
    op(1'b0, 32'h55, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 0);

    // Test 5: stalled RAM request, then reset in the middle of it
    mem_hold = 1'b1;
    issue(1'b0, 32'h77, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("stall_mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("stall_mem_addr", mem_addr, 32'h77);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    op(1'b0, 32'h55, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1);
    op(1'b0, 32'h40, 32'h0, 1'b0, 32'hC0DE_0040, 1'b1, 1'b0, 1);
    op(1'b0, 32'h40, 32'h0, 1'b1, 32'hC0DE_0040, 1'b1, 1'b1, 0);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover_expectations: %0d pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
